muldiv_ctrl: RTL

// - Sequences the EX-stage multiply/divide resource and owns the architectural HI/LO registers.
// - MULT/MULTU complete in 1 cycle.
// - DIV/DIVU run a 32-iteration radix-2 divider and hold the pipeline through stall_req.
// - Sits beside the ALU and is fed from ID-EX with alu_op, src_data1 and src_data2.

---
 rtl/muldiv_ctrl_pkg.sv | 33 +++
 rtl/muldiv_ctrl_div_step.sv | 34 +++
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : muldiv_ctrl_pkg
//  Description: Shared opcodes, FSM encoding and defaults for the EX-stage
//               multiply/divide controller.
//  Revision   : 1.0  initial release
// ============================================================================
package muldiv_ctrl_pkg;

    // ALU operation codes recognised by the multiply/divide resource
    localparam logic [4:0] c_ALU_MULT  = 5'd16;
    localparam logic [4:0] c_ALU_MULTU = 5'd17;
    localparam logic [4:0] c_ALU_DIV   = 5'd18;
    localparam logic [4:0] c_ALU_DIVU  = 5'd19;

    // Controller state encoding
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int          c_DIV_ITER_DEF = 32;
    localparam logic [31:0] c_DIV0_LO_DEF  = 32'hFFFF_FFFF;

    // Magnitude of a 32-bit operand; only negative values are negated, and
    // only when the operation is signed.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_div_step.sv
`default_nettype none
// ============================================================================
//  Module     : muldiv_ctrl_div_step
//  Description: One combinational restoring-division iteration. Shifts the
//               next dividend bit into the partial remainder and subtracts the
//               divisor when it fits, shifting the quotient bit in.
//  Revision   : 1.0  initial release
// ============================================================================
module muldiv_ctrl_div_step (
    input  logic [32:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [32:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // The quotient register doubles as the dividend shift register: its MSB is
    // the next dividend bit to bring down.
    assign w_shift = {i_rem[31:0], i_quo[31]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_fits  = i_rem[32] | (w_shift >= {1'b0, i_divisor});

    // Restore (keep the shifted remainder) when the divisor does not fit
    always_comb begin
        o_rem = w_fits ? w_diff : w_shift;
        o_quo = {i_quo[30:0], w_fits};
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : muldiv_ctrl
//  Description: EX-stage multiply/divide sequencer owning HI/LO. Multiplies
//               retire in one cycle; divides run a radix-2 restoring loop and
//               hold the pipeline through stall_req.
//  Revision   : 1.0  initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int          DIV_ITER = c_DIV_ITER_DEF,
    parameter logic [31:0] DIV0_LO  = c_DIV0_LO_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  alu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        annul,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int                 c_CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV_ITER - 1);

    md_state_e          r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [32:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_divisor;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic        w_b_zero;
    logic        w_accept;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [32:0] w_rem_n;
    logic [31:0] w_quo_n;

    assign w_is_mul = (alu_op == c_ALU_MULT) || (alu_op == c_ALU_MULTU);
    assign w_is_div = (alu_op == c_ALU_DIV)  || (alu_op == c_ALU_DIVU);
    assign w_signed = (alu_op == c_ALU_MULT) || (alu_op == c_ALU_DIV);
    assign w_b_zero = (src_b == 32'd0);
    assign w_accept = (r_state == MD_IDLE) && start && !annul;

    // One shared multiplier: operands are sign- or zero-extended to 64 bits so
    // the low 64 bits of the product are correct for both MULT and MULTU.
    assign w_mul_a = {{32{w_signed & src_a[31]}}, src_a};
    assign w_mul_b = {{32{w_signed & src_b[31]}}, src_b};
    assign w_prod  = w_mul_a * w_mul_b;

    muldiv_ctrl_div_step u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_n),
        .o_quo     (w_quo_n)
    );

    // Hold the pipeline from the accepting cycle of a real divide through the
    // last iteration; an annul drops the request in the same cycle.
    assign stall_req = ((r_state == MD_RUN) && !annul)
                     || (w_accept && w_is_div && !w_b_zero);

    // Controller FSM, divider datapath and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MD_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_hi   <= w_prod[63:32];
                        r_lo   <= w_prod[31:0];
                        r_done <= 1'b1;
                    end else if (w_accept && w_is_div && w_b_zero) begin
                        r_hi   <= src_a;
                        r_lo   <= DIV0_LO;
                        r_done <= 1'b1;
                    end else if (w_accept && w_is_div) begin
                        r_rem     <= '0;
                        r_quo     <= abs32(src_a, w_signed);
                        r_divisor <= abs32(src_b, w_signed);
                        r_qneg    <= w_signed & (src_a[31] ^ src_b[31]);
                        r_rneg    <= w_signed & src_a[31];
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    if (annul) begin
                        r_busy  <= 1'b0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_rem   <= w_rem_n;
                        r_quo   <= w_quo_n;
                        r_count <= r_count + 1'b1;
                        // Final iteration: commit signed results so they are
                        // visible together with done in the DONE cycle.
                        if (r_count == c_LAST) begin
                            r_lo    <= r_qneg ? (32'd0 - w_quo_n) : w_quo_n;
                            r_hi    <= r_rneg ? (32'd0 - w_rem_n[31:0]) : w_rem_n[31:0];
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    // The divide has already retired; start here is the same
                    // instruction leaving EX, so it is not re-accepted.
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire
